acf_sweep_scheduler: RTL and testbench
======================================

# acf_sweep_scheduler

Sequences the autocorrelation BPM engine: decides when a lag sweep starts, arbitrating between beat-triggered and periodic requests. Also enforces history warm-up and minimum inter-sweep spacing, watchdogs hung sweeps, and validates and holds results. It sits between the onset/flux front end and the autocorrelation engine, and drives the engine's start input and abort (engine reset) input.

## Interface
- `WARMUP_FRAMES`, default 300: flux frames required before the first sweep (history fill).
- `MIN_GAP_FRAMES`, default 16: minimum number of frames between sweep starts.
- `PERIOD_FRAMES`, default 64: a sweep is forced once this many frames pass without one.
- `TIMEOUT_CYCLES`, default 200000: clock cycles allowed per sweep before abort.
- `RECOVER_CYCLES`, default 4: hold-off cycles after an abort.
- `STALE_FRAMES`, default 256: frames without an accepted result before `stale` asserts.
- `MIN_BPM`, default 40: lower bound of accepted results.
- `MAX_BPM`, default 240: upper bound of accepted results.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  permits new sweep starts.
- `flux_valid`  in  1  frame tick.
- `beat_valid`  in  1  beat flag, qualified by `flux_valid`.
- `eng_busy`  in  1  engine not idle.
- `eng_done`  in  1  engine result pulse.
- `eng_bpm`  in  16  engine result, valid with `eng_done`.
- `eng_start`  out  1  one-cycle sweep request.
- `eng_abort`  out  1  one-cycle engine reset.
- `bpm_hold`  out  16  last accepted BPM.
- `bpm_out_valid`  out  1  pulse on acceptance.
- `stale`  out  1  no recent accepted result.
- `src_beat`  out  1  the current or last sweep was beat-triggered (0 means periodic).
- `timeout_count`  out  8  saturating count of aborts.
- `reject_count`  out  8  saturating count of out-of-range results.
- `state_out`  out  2  current state: 0 WARMUP, 1 READY, 2 RUN, 3 RECOVER.

## Operation
- Reset values:
  - state WARMUP.
  - All pulses 0.
  - `bpm_hold`=0, `src_beat`=0, counts 0.
  - `stale`=1.
  - Internal counters 0, `beat_pend`=0.
- `frame_cnt` increments on `flux_valid`, saturating at `WARMUP_FRAMES`.
- WARMUP→READY on the edge where `frame_cnt` reaches `WARMUP_FRAMES`.
- `gap_cnt` increments on `flux_valid`, saturating at `PERIOD_FRAMES`. It is cleared on a start; a clear in the same cycle wins over an increment.
- `beat_pend` is set by `flux_valid`&`beat_valid` outside WARMUP (beats in WARMUP are discarded). It is cleared on a start; the clear wins, so a beat in the start cycle is consumed.
- READY start condition: `enable` & !`eng_busy` & `gap_cnt`≥`MIN_GAP_FRAMES` & (`beat_pend` | `gap_cnt`≥`PERIOD_FRAMES`). Actions on start:
  - Pulse `eng_start`.
  - `src_beat` ← `beat_pend`.
  - Clear the timer.
  - Go to RUN.
- RUN:
  - The timer increments every cycle.
  - On `eng_done`: if `MIN_BPM`≤`eng_bpm`≤`MAX_BPM`, then `bpm_hold` ← `eng_bpm`, pulse `bpm_out_valid`, clear the stale counter. Otherwise increment `reject_count`. In either case go to READY.
  - Timeout: when the timer equals `TIMEOUT_CYCLES`-1 without `eng_done`, pulse `eng_abort`, increment `timeout_count`, and go to RECOVER.
  - `eng_done` and timeout in the same cycle: done wins, no abort.
- RECOVER: count `RECOVER_CYCLES` cycles, then go to READY once `eng_busy`=0. Stay in RECOVER while `eng_busy` remains high.
- `eng_done` outside RUN is ignored: no capture, no count.
- `enable` low blocks starts only. A sweep already in RUN completes or times out normally.
- `stale_cnt` increments on `flux_valid`, saturating at `STALE_FRAMES`. `stale` = (`stale_cnt`==`STALE_FRAMES`) | (no result accepted since reset).
- Reset mid-RUN returns every register to its reset value at the next edge. No `eng_abort` is issued, because the engine shares the reset.

## Timing
- All outputs are registered.
- `eng_start` is high for the single cycle following the edge that sampled the READY start condition true; `state_out`=2 in that same cycle.
- Acceptance: `bpm_hold` and `bpm_out_valid` update on the edge after `eng_done` is sampled; `state_out` is 1 in that cycle.
- Earliest next start: the following edge, subject to the gap and request rules.
- The abort pulse appears `TIMEOUT_CYCLES` cycles after the `eng_start` cycle.
- Start-to-start spacing is at least `MIN_GAP_FRAMES` `flux_valid` ticks.
- Saturating counts hold at 255.

## Test plan
Parameters for all tests: `WARMUP_FRAMES`=8, `MIN_GAP_FRAMES`=4, `PERIOD_FRAMES`=16, `TIMEOUT_CYCLES`=50, `RECOVER_CYCLES`=4, `STALE_FRAMES`=32.
- **Warm-up:** beats on frames 1–7 → no `eng_start`; `state_out`=1 after frame 8; `beat_pend`=0 (no start until a new beat arrives and the gap is satisfied).
- **Beat start and accept:** beat at frame 12, engine returns `eng_done` with `eng_bpm`=120 after 20 cycles → one `eng_start`, `src_beat`=1, `bpm_hold`=120, single `bpm_out_valid`, `stale`=0.
- **Min-gap suppression:** beats on two consecutive frames, with the first sweep done quickly → the second start waits until 4 frames after the first; exactly one start per gap window.
- **Periodic force:** no beats after warm-up → a start at `gap_cnt`=16 with `src_beat`=0.
- **Timeout:** engine never sends `eng_done` → `eng_abort` 50 cycles after start; `timeout_count`=1; READY is re-entered after 4 cycles with `eng_busy`=0. A separate case has `eng_done` land on cycle 49 → accepted, no abort.
- **Reject and reset:**
  - `eng_bpm`=300 → `reject_count`=1; `bpm_hold` unchanged; no valid pulse.
  - `reset` asserted mid-RUN → next cycle shows `state_out`=0, all outputs at reset values, `stale`=1.

Source files
------------

// File: rtl/acf_sweep_scheduler.sv
// acf_sweep_scheduler: decides when the autocorrelation engine sweeps,
// arbitrating beat vs periodic requests, watchdogging and validating results.
module acf_sweep_scheduler #(
  parameter int WARMUP_FRAMES  = 300,
  parameter int MIN_GAP_FRAMES = 16,
  parameter int PERIOD_FRAMES  = 64,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int RECOVER_CYCLES = 4,
  parameter int STALE_FRAMES   = 256,
  parameter int MIN_BPM        = 40,
  parameter int MAX_BPM        = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flux_valid,
  input  logic        beat_valid,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic [15:0] eng_bpm,
  output logic        eng_start,
  output logic        eng_abort,
  output logic [15:0] bpm_hold,
  output logic        bpm_out_valid,
  output logic        stale,
  output logic        src_beat,
  output logic [7:0]  timeout_count,
  output logic [7:0]  reject_count,
  output logic [1:0]  state_out
);
  localparam int FW = $clog2(WARMUP_FRAMES + 1);
  localparam int GW = $clog2(PERIOD_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  localparam int SW = $clog2(STALE_FRAMES + 1);

  typedef enum logic [1:0] {
    S_WARMUP  = 2'd0,
    S_READY   = 2'd1,
    S_RUN     = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [FW-1:0] frame_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] timer;
  logic [RW-1:0] rec_cnt;
  logic [SW-1:0] stale_cnt;
  logic          beat_pend;
  logic          start;
  logic          accept;
  logic          reject;
  logic          timeout;
  logic          bpm_ok;
  logic          gap_ok;
  logic          req;

  assign bpm_ok = (eng_bpm >= 16'(MIN_BPM)) &&
                  (eng_bpm <= 16'(MAX_BPM));
  assign gap_ok = gap_cnt >= GW'(MIN_GAP_FRAMES);
  assign req    = beat_pend || (gap_cnt >= GW'(PERIOD_FRAMES));
  assign state_out = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_WARMUP;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    timeout = 1'b0;
    unique case (state)
      S_WARMUP: begin
        if (flux_valid &&
            frame_cnt == FW'(WARMUP_FRAMES - 1))
          state_n = S_READY;
      end
      S_READY: begin
        if (enable && !eng_busy && gap_ok && req) begin
          start   = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        // a result arriving on the last allowed cycle beats the watchdog
        if (eng_done) begin
          accept  = bpm_ok;
          reject  = !bpm_ok;
          state_n = S_READY;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_n = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (rec_cnt == RW'(RECOVER_CYCLES - 1) && !eng_busy)
          state_n = S_READY;
      end
      default: state_n = S_WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt     <= '0;
      gap_cnt       <= '0;
      timer         <= '0;
      rec_cnt       <= '0;
      stale_cnt     <= '0;
      beat_pend     <= 1'b0;
      eng_start     <= 1'b0;
      eng_abort     <= 1'b0;
      bpm_out_valid <= 1'b0;
      bpm_hold      <= '0;
      src_beat      <= 1'b0;
      stale         <= 1'b1;
      timeout_count <= '0;
      reject_count  <= '0;
    end else begin
      eng_start     <= start;
      eng_abort     <= timeout;
      bpm_out_valid <= accept;

      if (flux_valid && frame_cnt != FW'(WARMUP_FRAMES))
        frame_cnt <= frame_cnt + 1'b1;

      if (start)
        gap_cnt <= '0;
      else if (flux_valid && gap_cnt != GW'(PERIOD_FRAMES))
        gap_cnt <= gap_cnt + 1'b1;

      // a beat in the start cycle is absorbed by that sweep
      if (start)
        beat_pend <= 1'b0;
      else if (flux_valid && beat_valid && state != S_WARMUP)
        beat_pend <= 1'b1;

      if (start)
        src_beat <= beat_pend;

      if (start)
        timer <= '0;
      else if (state == S_RUN)
        timer <= timer + 1'b1;

      if (timeout)
        rec_cnt <= '0;
      else if (state == S_RECOVER &&
               rec_cnt != RW'(RECOVER_CYCLES - 1))
        rec_cnt <= rec_cnt + 1'b1;

      if (accept)
        bpm_hold <= eng_bpm;

      if (timeout && timeout_count != 8'hFF)
        timeout_count <= timeout_count + 1'b1;

      if (reject && reject_count != 8'hFF)
        reject_count <= reject_count + 1'b1;

      if (accept) begin
        stale_cnt <= '0;
        stale     <= 1'b0;
      end else if (flux_valid &&
                   stale_cnt != SW'(STALE_FRAMES)) begin
        stale_cnt <= stale_cnt + 1'b1;
        if (stale_cnt == SW'(STALE_FRAMES - 1))
          stale <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_acf_sweep_scheduler.sv
// tb_acf_sweep_scheduler: scenario tasks plus an event scoreboard for
// eng_start / bpm_out_valid / eng_abort on the scheduler.
module tb_acf_sweep_scheduler;
  logic        clk;
  logic        reset;
  logic        enable;
  logic        flux_valid;
  logic        beat_valid;
  logic        eng_busy;
  logic        eng_done;
  logic [15:0] eng_bpm;
  logic        eng_start;
  logic        eng_abort;
  logic [15:0] bpm_hold;
  logic        bpm_out_valid;
  logic        stale;
  logic        src_beat;
  logic [7:0]  timeout_count;
  logic [7:0]  reject_count;
  logic [1:0]  state_out;

  int vectors = 0;
  int miscompares = 0;

  localparam int K_START = 0;
  localparam int K_ACC   = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int          kind;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  acf_sweep_scheduler #(
    .WARMUP_FRAMES (8),
    .MIN_GAP_FRAMES(4),
    .PERIOD_FRAMES (16),
    .TIMEOUT_CYCLES(50),
    .RECOVER_CYCLES(4),
    .STALE_FRAMES  (32),
    .MIN_BPM       (40),
    .MAX_BPM       (240)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .flux_valid   (flux_valid),
    .beat_valid   (beat_valid),
    .eng_busy     (eng_busy),
    .eng_done     (eng_done),
    .eng_bpm      (eng_bpm),
    .eng_start    (eng_start),
    .eng_abort    (eng_abort),
    .bpm_hold     (bpm_hold),
    .bpm_out_valid(bpm_out_valid),
    .stale        (stale),
    .src_beat     (src_beat),
    .timeout_count(timeout_count),
    .reject_count (reject_count),
    .state_out    (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every output event must match the head of exp_q
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic        hit;
      logic [15:0] d;
      hit = (k == K_START) ? eng_start :
            (k == K_ACC)   ? bpm_out_valid : eng_abort;
      d   = (k == K_START) ? {15'd0, src_beat} :
            (k == K_ACC)   ? bpm_hold : {8'd0, timeout_count};
      if (hit === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got kind %0d data %0h, want no event",
                   k, d);
        end else begin
          if (exp_q[0].kind != k || exp_q[0].data !== d) begin
            miscompares++;
            $display("FAIL sb_event: got kind %0d data %0h, want kind %0d data %0h",
                     k, d, exp_q[0].kind, exp_q[0].data);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input int k, input logic [15:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic frame(input logic b);
    flux_valid = 1'b1;
    beat_valid = b;
    @(negedge clk);
    flux_valid = 1'b0;
    beat_valid = 1'b0;
  endtask

  // brings gap from 0 to MIN_GAP with a beat on the last frame
  task automatic beat_start(output logic found);
    found = 1'b0;
    repeat (3) frame(1'b0);
    push_exp(K_START, 16'd1);
    frame(1'b1);
    for (int i = 0; i < 4 && !found; i++) begin
      step();
      found = (eng_start === 1'b1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    vectors++;
    if ({state_out, eng_start, eng_abort, bpm_out_valid, stale, src_beat}
        !== 7'b00_0001_0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want %b",
               {state_out, eng_start, eng_abort, bpm_out_valid, stale, src_beat},
               7'b00_0001_0);
    end
    vectors++;
    if ({bpm_hold, timeout_count, reject_count} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_regs: got %h want 0",
               {bpm_hold, timeout_count, reject_count});
    end
    reset = 1'b0;
  endtask

  task automatic test_warmup();
    for (int f = 1; f <= 7; f++) begin
      frame(1'b1);
      step();
    end
    vectors++;
    if (state_out !== 2'd0) begin
      miscompares++;
      $display("FAIL warmup_hold: got state %0d want 0", state_out);
    end
    frame(1'b0);
    vectors++;
    if (state_out !== 2'd1) begin
      miscompares++;
      $display("FAIL warmup_exit: got state %0d want 1", state_out);
    end
    repeat (6) step();
    vectors++;
    if (state_out !== 2'd1) begin
      miscompares++;
      $display("FAIL warmup_beats_dropped: got state %0d want 1", state_out);
    end
  endtask

  task automatic test_beat_accept();
    repeat (3) frame(1'b0);
    push_exp(K_START, 16'd1);
    frame(1'b1);
    step();
    vectors++;
    if ({eng_start, state_out, src_beat} !== 4'b1_10_1) begin
      miscompares++;
      $display("FAIL beat_start: got %b want 1101",
               {eng_start, state_out, src_beat});
    end
    eng_busy = 1'b1;
    repeat (19) step();
    eng_done = 1'b1;
    eng_bpm  = 16'd120;
    push_exp(K_ACC, 16'd120);
    step();
    eng_done = 1'b0;
    eng_busy = 1'b0;
    vectors++;
    if ({bpm_out_valid, state_out, stale} !== 4'b1_01_0 ||
        bpm_hold !== 16'd120) begin
      miscompares++;
      $display("FAIL beat_accept: got v/st/stale %b bpm %0d want 1010 bpm 120",
               {bpm_out_valid, state_out, stale}, bpm_hold);
    end
    step();
    vectors++;
    if (bpm_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_pulse: got %b want 0", bpm_out_valid);
    end
  endtask

  task automatic test_min_gap();
    repeat (3) frame(1'b0);
    push_exp(K_START, 16'd1);
    frame(1'b1);
    frame(1'b1);
    vectors++;
    if ({eng_start, state_out} !== 3'b1_10) begin
      miscompares++;
      $display("FAIL gap_first_start: got %b want 110", {eng_start, state_out});
    end
    eng_done = 1'b1;
    eng_bpm  = 16'd100;
    push_exp(K_ACC, 16'd100);
    step();
    eng_done = 1'b0;
    repeat (4) frame(1'b0);
    repeat (3) step();
    vectors++;
    if (state_out !== 2'd1) begin
      miscompares++;
      $display("FAIL gap_beat_consumed: got state %0d want 1", state_out);
    end
    push_exp(K_START, 16'd1);
    frame(1'b1);
    step();
    vectors++;
    if (eng_start !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_second_start: got %b want 1", eng_start);
    end
    eng_done = 1'b1;
    eng_bpm  = 16'd105;
    push_exp(K_ACC, 16'd105);
    step();
    eng_done = 1'b0;
    frame(1'b1);
    frame(1'b0);
    frame(1'b0);
    repeat (2) step();
    vectors++;
    if (state_out !== 2'd1) begin
      miscompares++;
      $display("FAIL gap_suppress: got state %0d want 1", state_out);
    end
    push_exp(K_START, 16'd1);
    frame(1'b0);
    step();
    vectors++;
    if (eng_start !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_release: got %b want 1", eng_start);
    end
    eng_done = 1'b1;
    eng_bpm  = 16'd110;
    push_exp(K_ACC, 16'd110);
    step();
    eng_done = 1'b0;
  endtask

  task automatic test_periodic();
    repeat (15) frame(1'b0);
    step();
    vectors++;
    if (state_out !== 2'd1) begin
      miscompares++;
      $display("FAIL periodic_early: got state %0d want 1", state_out);
    end
    push_exp(K_START, 16'd0);
    frame(1'b0);
    step();
    vectors++;
    if ({eng_start, src_beat} !== 2'b10) begin
      miscompares++;
      $display("FAIL periodic_start: got %b want 10", {eng_start, src_beat});
    end
    eng_done = 1'b1;
    eng_bpm  = 16'd60;
    push_exp(K_ACC, 16'd60);
    step();
    eng_done = 1'b0;
  endtask

  task automatic test_timeout();
    logic       found;
    logic       early;
    logic [7:0] trace;
    beat_start(found);
    vectors++;
    if (found !== 1'b1) begin
      miscompares++;
      $display("FAIL to_start: got %b want 1", found);
    end
    push_exp(K_ABORT, 16'd1);
    eng_busy = 1'b1;
    early = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k < 50 && eng_abort === 1'b1) early = 1'b1;
    end
    vectors++;
    if ({early, eng_abort, state_out} !== 4'b0_1_11 ||
        timeout_count !== 8'd1) begin
      miscompares++;
      $display("FAIL to_abort: got early/abort/st %b cnt %0d want 0111 cnt 1",
               {early, eng_abort, state_out}, timeout_count);
    end
    eng_busy = 1'b0;
    trace = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      trace = {trace[5:0], state_out};
    end
    vectors++;
    if (trace !== 8'b11_11_11_01) begin
      miscompares++;
      $display("FAIL to_recover: got %b want 11111101", trace);
    end
  endtask

  task automatic test_done_last_cycle();
    logic found;
    beat_start(found);
    vectors++;
    if (found !== 1'b1) begin
      miscompares++;
      $display("FAIL d49_start: got %b want 1", found);
    end
    eng_busy = 1'b1;
    repeat (49) step();
    eng_done = 1'b1;
    eng_bpm  = 16'd90;
    push_exp(K_ACC, 16'd90);
    step();
    eng_done = 1'b0;
    eng_busy = 1'b0;
    vectors++;
    if ({bpm_out_valid, eng_abort, state_out} !== 4'b1_0_01 ||
        timeout_count !== 8'd1) begin
      miscompares++;
      $display("FAIL d49_accept: got v/abort/st %b cnt %0d want 1001 cnt 1",
               {bpm_out_valid, eng_abort, state_out}, timeout_count);
    end
    step();
    vectors++;
    if (eng_abort !== 1'b0) begin
      miscompares++;
      $display("FAIL d49_no_abort: got %b want 0", eng_abort);
    end
  endtask

  task automatic test_reject();
    logic found;
    beat_start(found);
    eng_done = 1'b1;
    eng_bpm  = 16'd300;
    step();
    eng_done = 1'b0;
    vectors++;
    if (found !== 1'b1 || reject_count !== 8'd1 || bpm_hold !== 16'd90 ||
        {bpm_out_valid, state_out} !== 3'b0_01) begin
      miscompares++;
      $display("FAIL rej_300: got cnt %0d bpm %0d v/st %b want cnt 1 bpm 90 v/st 001",
               reject_count, bpm_hold, {bpm_out_valid, state_out});
    end
    beat_start(found);
    eng_done = 1'b1;
    eng_bpm  = 16'd39;
    step();
    eng_done = 1'b0;
    vectors++;
    if (reject_count !== 8'd2 || bpm_hold !== 16'd90) begin
      miscompares++;
      $display("FAIL rej_39: got cnt %0d bpm %0d want cnt 2 bpm 90",
               reject_count, bpm_hold);
    end
    eng_done = 1'b1;
    eng_bpm  = 16'd150;
    step();
    eng_done = 1'b0;
    vectors++;
    if (reject_count !== 8'd2 || bpm_hold !== 16'd90) begin
      miscompares++;
      $display("FAIL done_idle: got cnt %0d bpm %0d want cnt 2 bpm 90",
               reject_count, bpm_hold);
    end
    beat_start(found);
    eng_done = 1'b1;
    eng_bpm  = 16'd240;
    push_exp(K_ACC, 16'd240);
    step();
    eng_done = 1'b0;
    vectors++;
    if (bpm_hold !== 16'd240 || stale !== 1'b0) begin
      miscompares++;
      $display("FAIL acc_240: got bpm %0d stale %b want bpm 240 stale 0",
               bpm_hold, stale);
    end
  endtask

  task automatic test_stale();
    enable = 1'b0;
    repeat (31) frame(1'b0);
    vectors++;
    if (stale !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_31: got %b want 0", stale);
    end
    frame(1'b0);
    step();
    vectors++;
    if ({stale, state_out} !== 3'b1_01) begin
      miscompares++;
      $display("FAIL stale_32: got stale/st %b want 101", {stale, state_out});
    end
  endtask

  task automatic test_reset_mid_run();
    enable = 1'b1;
    push_exp(K_START, 16'd0);
    step();
    vectors++;
    if ({eng_start, state_out} !== 3'b1_10) begin
      miscompares++;
      $display("FAIL mr_start: got %b want 110", {eng_start, state_out});
    end
    eng_busy = 1'b1;
    repeat (5) step();
    reset = 1'b1;
    step();
    vectors++;
    if ({state_out, eng_start, eng_abort, bpm_out_valid, stale, src_beat}
        !== 7'b00_0001_0 ||
        {bpm_hold, timeout_count, reject_count} !== 32'd0) begin
      miscompares++;
      $display("FAIL mr_reset: got flags %b regs %h want 0000010 regs 0",
               {state_out, eng_start, eng_abort, bpm_out_valid, stale, src_beat},
               {bpm_hold, timeout_count, reject_count});
    end
    reset    = 1'b0;
    eng_busy = 1'b0;
    step();
    vectors++;
    if ({state_out, eng_abort} !== 3'b00_0) begin
      miscompares++;
      $display("FAIL mr_after: got %b want 000", {state_out, eng_abort});
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    flux_valid = 1'b0;
    beat_valid = 1'b0;
    eng_busy   = 1'b0;
    eng_done   = 1'b0;
    eng_bpm    = 16'd0;
    test_reset();
    test_warmup();
    test_beat_accept();
    test_min_gap();
    test_periodic();
    test_timeout();
    test_done_last_cycle();
    test_reject();
    test_stale();
    test_reset_mid_run();
    repeat (2) step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d pending events want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
